// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches one operation, registers the result.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin contention handling; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*BUS_WIDTH-1:0] req_a,
    input  logic [2*BUS_WIDTH-1:0] req_b,
    input  logic [1:0]             req_carry_in,
    input  logic [7:0]             req_opcode,
    output logic [BUS_WIDTH-1:0]   alu_a,
    output logic [BUS_WIDTH-1:0]   alu_b,
    output logic                   alu_carry_in,
    output logic [3:0]             alu_opcode,
    input  logic [BUS_WIDTH-1:0]   alu_y,
    input  logic                   alu_carry_out,
    input  logic                   alu_borrow,
    input  logic                   alu_zero,
    input  logic                   alu_parity,
    input  logic                   alu_invalid_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [BUS_WIDTH-1:0]   rsp_y,
    output logic                   rsp_carry_out,
    output logic                   rsp_borrow,
    output logic                   rsp_zero,
    output logic                   rsp_parity,
    output logic                   rsp_invalid_op
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    state_t               state_next;
    logic [BUS_WIDTH-1:0] a_q;
    logic [BUS_WIDTH-1:0] b_q;
    logic                 carry_in_q;
    logic [3:0]           opcode_q;
    logic                 id_q;
    logic                 last_grant;
    logic                 grant_id;
    logic                 accept;

    // Pick a winner; a lone requester wins regardless of history.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            grant_id = ~last_grant;
`else
            grant_id = 1'b0;
`endif
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

`ifndef ALU_ARBITER_ROUND_ROBIN_EN
    // History is kept in fixed-priority builds too, it just never steers the grant.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign accept    = (state == IDLE) && (|req_valid) && !rst;
    assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The operation is captured only on the accept cycle, so later req_* changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_in_q <= 1'b0;
            opcode_q   <= 4'h0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            a_q        <= grant_id ? req_a[2*BUS_WIDTH-1:BUS_WIDTH] : req_a[BUS_WIDTH-1:0];
            b_q        <= grant_id ? req_b[2*BUS_WIDTH-1:BUS_WIDTH] : req_b[BUS_WIDTH-1:0];
            carry_in_q <= req_carry_in[grant_id];
            opcode_q   <= grant_id ? req_opcode[7:4] : req_opcode[3:0];
            id_q       <= grant_id;
            last_grant <= grant_id;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_carry_in = carry_in_q;
    assign alu_opcode   = opcode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id         <= 1'b0;
            rsp_y          <= '0;
            rsp_carry_out  <= 1'b0;
            rsp_borrow     <= 1'b0;
            rsp_zero       <= 1'b0;
            rsp_parity     <= 1'b0;
            rsp_invalid_op <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id         <= id_q;
            rsp_y          <= alu_y;
            rsp_carry_out  <= alu_carry_out;
            rsp_borrow     <= alu_borrow;
            rsp_zero       <= alu_zero;
            rsp_parity     <= alu_parity;
            rsp_invalid_op <= alu_invalid_op;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, meaning the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  2  bit N set: requester N offers an operation.
REQ-005 SHALL have port req_ready  output  2  bit N set: requester N's operation is accepted this cycle.
REQ-006 SHALL have port req_a  input  2*BUS_WIDTH  operand A; requester N in bits [N*BUS_WIDTH +: BUS_WIDTH].
REQ-007 SHALL have port req_b  input  2*BUS_WIDTH  operand B, packed the same way as req_a.
REQ-008 SHALL have port req_carry_in  input  2  carry-in; bit N belongs to requester N.
REQ-009 SHALL have port req_opcode  input  8  opcode; requester N in bits [4N+3:4N].
REQ-010 SHALL have ports alu_a, alu_b (BUS_WIDTH), alu_carry_in (1) and alu_opcode (4), all outputs, which drive the shared ALU.
REQ-011 SHALL have ports alu_y (BUS_WIDTH) and alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op (1 each), all inputs, which return the ALU's combinational result.
REQ-012 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1) forming the response handshake.
REQ-013 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-014 SHALL have ports rsp_y (BUS_WIDTH) and rsp_carry_out, rsp_borrow, rsp_zero, rsp_parity, rsp_invalid_op (1 each), all outputs, carrying the registered ALU result and flags.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, EXEC and RESP.
REQ-016 In IDLE with any req_valid bit set, SHALL grant exactly one requester, assert only that requester's req_ready bit for one cycle, latch its a, b, carry_in and opcode together with its index, and move to EXEC.
REQ-017 SHALL drive req_ready combinationally as 0 in every state except IDLE, and 0 for any requester that is not granted.
REQ-018 SHALL drive alu_a, alu_b, alu_carry_in and alu_opcode from the latched registers at all times, so they are stable throughout EXEC and RESP.
REQ-019 In EXEC, SHALL register all ALU outputs and the granted index into the rsp_* registers, then move to RESP.
REQ-020 In RESP, SHALL hold rsp_valid=1 and all rsp_* values stable; when rsp_ready=1 it SHALL return to IDLE, with rsp_valid=0 from the next cycle.
REQ-021 Latency: for an operation accepted in cycle T, rsp_valid SHALL first be asserted in cycle T+2. There is no pipelining, so peak throughput is one operation per 3 cycles.
REQ-022 SHALL maintain a last_grant register that is updated on every grant.
REQ-023 Both requesters valid in IDLE: SHALL grant per REQ-036/REQ-037.
REQ-024 Only one requester valid: SHALL grant that requester regardless of last_grant.
REQ-025 An invalid opcode (0 or 10-15) SHALL still complete normally, returning rsp_invalid_op=1 and rsp_y=0, with no stall or drop.
REQ-026 If req_valid drops while the FSM is not in IDLE, there SHALL be no effect, because the operation is latched only at the accept cycle.
REQ-027 A back-to-back request from the same requester SHALL NOT be accepted earlier than the cycle after the handshake in which rsp_ready=1 is seen.

Reset
REQ-028 While rst=1, state SHALL be IDLE, and req_ready, rsp_valid, rsp_id, rsp_y and all rsp_* flags SHALL be 0.
REQ-029 While rst=1, the latched operand and opcode registers SHALL be 0, so that alu_* outputs are 0.
REQ-030 While rst=1, last_grant SHALL be 1, so requester 0 wins the first contention.
REQ-031 Reset asserted in EXEC or RESP SHALL abort the operation immediately with no response issued, and the requester SHALL NOT be re-notified.
REQ-032 After rst deasserts, the first grant SHALL be possible on the first rising clk edge.

Configuration
REQ-033 Macro ALU_ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-034 With the macro defined, contention SHALL be resolved round-robin.
REQ-035 Without the macro, contention SHALL be resolved by fixed priority.
REQ-036 Round-robin (macro defined): on contention, SHALL grant the requester whose index differs from last_grant.
REQ-037 Fixed priority (macro undefined): on contention, SHALL always grant requester 0. The last_grant register is still maintained but unused.

Verification
REQ-038 Single request: req_valid=01, req_a[7:0]=0x0F, req_b[7:0]=0x01, opcode 1 (add), with rsp_ready=1 -> req_ready=01 at T, rsp_valid at T+2, rsp_y=0x10, rsp_id=0, zero=0, parity=1.
REQ-039 Add with carry: requester 1, a=0xFF, b=0x00, carry_in=1, opcode 2 -> rsp_y=0x00, carry_out=1, zero=1, rsp_id=1.
REQ-040 Contention with the macro defined: req_valid=11 held for two transactions -> grants are 0 then 1. Without the macro -> grants are 0 then 0.
REQ-041 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_y stay stable and req_ready stays 00. Setting rsp_ready=1 -> IDLE on the next cycle.
REQ-042 Invalid opcode 0xC -> rsp_invalid_op=1, rsp_y=0, zero=1, parity=0.
REQ-043 Reset asserted in RESP -> rsp_valid=0 and req_ready=00 immediately, and a subsequent request is served normally.
